param_stream_loader: RTL and testbench

Streaming-writable parameter memory: the receive-side counterpart of the ROM-backed parameter sources. Accepts one tensor (bias/weight slice) over a valid/ready input stream, stores it in an internal 2-cycle-latency RAM, then replays it cyclically on a valid/ready output stream with full backpressure support. Sits between the host/DMA parameter loader and a layer's parameter port. A new tensor can be loaded at runtime without resynthesis.

---
 rtl/param_stream_loader.sv | 135 +++++++++++++
 tb/tb_param_stream_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_stream_loader.sv
// param_stream_loader: accepts one tensor over a valid/ready stream into an
// internal RAM, then replays it cyclically on a backpressured output stream.
// A reload pulse returns to loading at any time without resynthesis.
module param_stream_loader #(
    parameter int PRECISION_0       = 16,
    parameter int PRECISION_1       = 3,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reload,
    input  logic [PRECISION_0-1:0] data_in [PARALLELISM_DIM_0],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   load_done,
    output logic [PRECISION_0-1:0] data_out [PARALLELISM_DIM_0],
    output logic                   data_out_valid,
    input  logic                   data_out_ready
);

    localparam int WORD_W = PRECISION_0 * PARALLELISM_DIM_0;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1) + 1;

    // Fractional bits are carried for documentation only; reject nonsense at elaboration.
    if (DEPTH < 2 || FIFO_DEPTH < 4 || PRECISION_1 > PRECISION_0) begin : g_bad_params
        $error("param_stream_loader: illegal parameter combination");
    end

    typedef enum logic {LOAD, SERVE} state_t;
    state_t state, state_next;

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WORD_W-1:0] ram [DEPTH];
    logic [WORD_W-1:0] word_in;
    logic [WORD_W-1:0] rd_data_p0, rd_data_p1;
    logic              vld_p0, vld_p1;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]     fifo_head, fifo_tail;
    logic [CW-1:0]     fifo_count, occupancy;
    logic              in_fire, last_beat, rd_issue, fifo_push, fifo_pop;

    // Ready depends only on state, reload and reset so the source never sees a loop.
    assign data_in_ready  = !rst && !reload && (state == LOAD);
    assign in_fire        = data_in_valid && data_in_ready;
    assign last_beat      = in_fire && (wr_ptr == AW'(DEPTH - 1));
    // Credit rule: FIFO entries plus reads still in the RAM pipeline never exceed FIFO_DEPTH.
    assign occupancy      = fifo_count + CW'(vld_p0) + CW'(vld_p1);
    assign rd_issue       = (state == SERVE) && (occupancy < CW'(FIFO_DEPTH));
    assign fifo_push      = vld_p1;
    assign data_out_valid = (fifo_count != '0);
    assign fifo_pop       = data_out_valid && data_out_ready;

    // Pack the input elements into one RAM word, element j at bits [PRECISION_0*j +: PRECISION_0].
    always_comb begin
        word_in = '0;
        for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
            word_in[PRECISION_0*j +: PRECISION_0] = data_in[j];
        end
    end

    // Unpack the show-ahead FIFO head onto the output elements.
    always_comb begin
        for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
            data_out[j] = fifo_mem[fifo_head][PRECISION_0*j +: PRECISION_0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // Next state: reload always wins; the final load beat enters SERVE.
    always_comb begin
        state_next = state;
        if (reload)                           state_next = LOAD;
        else if (state == LOAD && last_beat)  state_next = SERVE;
    end

    // Control: write/read pointers, load_done and the read-pipeline valid tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            load_done <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
        end else if (reload) begin
            wr_ptr    <= '0;
            load_done <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            if (last_beat) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                load_done <= 1'b1;
            end else if (in_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end else if (rd_issue) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            vld_p0 <= rd_issue;
            vld_p1 <= vld_p0;
        end
    end

    // Datapath: RAM write, two-stage registered read and FIFO storage (no reset on data).
    always_ff @(posedge clk) begin
        if (in_fire) ram[wr_ptr] <= word_in;
        rd_data_p0 <= ram[rd_ptr];
        rd_data_p1 <= rd_data_p0;
        if (fifo_push) fifo_mem[fifo_tail] <= rd_data_p1;
    end

    // FIFO pointers and occupancy; reload flushes everything buffered.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) fifo_tail <= (fifo_tail == FW'(FIFO_DEPTH - 1)) ? '0 : fifo_tail + FW'(1);
            if (fifo_pop)  fifo_head <= (fifo_head == FW'(FIFO_DEPTH - 1)) ? '0 : fifo_head + FW'(1);
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

endmodule

// File: tb/tb_param_stream_loader.sv
// Testbench for param_stream_loader: directed load/replay/backpressure/reload
// scenarios with a queue-based scoreboard and an independent output monitor.
module tb_param_stream_loader;

    logic        clk = 1'b0;
    logic        rst, reload, data_in_valid, data_in_ready, load_done;
    logic        data_out_valid, data_out_ready;
    logic [15:0] data_in [1];
    logic [15:0] data_out [1];

    int          n_cmp = 0, n_bad = 0, hs_count = 0, rep_idx = 0;
    logic [15:0] model [32];
    logic [15:0] exp_q [$];
    logic        stall_q = 1'b0;
    logic [15:0] stall_data = '0;

    always #5 clk = ~clk;

    param_stream_loader dut (
        .clk            (clk),
        .rst            (rst),
        .reload         (reload),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .load_done      (load_done),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
    always @(negedge clk) begin
        logic [15:0] e;
        if (stall_q) begin
            check("hold_valid", data_out_valid, 1);
            check("hold_data", data_out[0], stall_data);
        end
        if (data_out_valid && data_out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: actual 0x%0h required none", data_out[0]);
            end else begin
                e = exp_q.pop_front();
                check("beat", data_out[0], e);
            end
        end
        stall_q    = data_out_valid && !data_out_ready && !reload && !rst;
        stall_data = data_out[0];
    end

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model[rep_idx]);
            rep_idx = (rep_idx + 1) % 32;
        end
    endtask

    // Performs n load handshakes starting at address 0; called at posedge+1.
    task automatic load_beats(input logic [15:0] base, input bit gappy, input int n);
        int  got = 0;
        int  guard = 0;
        logic hs;
        while (got < n && guard < 1000) begin
            data_in[0]    = base + 16'(got);
            data_in_valid = gappy ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            check("in_ready_load", data_in_ready, 1);
            check("load_done_low", load_done, 0);
            hs = data_in_valid && data_in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                model[got] = base + 16'(got);
                got++;
            end
            guard++;
        end
        data_in_valid = 1'b0;
        check("load_count", got, n);
    endtask

    // Consumes exactly n beats, optionally with random ready and 10-cycle stalls.
    task automatic consume(input int n, input bit rnd);
        int start = hs_count;
        int cyc = 0;
        while (hs_count - start < n && cyc < 3000) begin
            if (!rnd)              data_out_ready = 1'b1;
            else if (cyc % 23 < 10) data_out_ready = 1'b0;
            else                   data_out_ready = 1'($urandom % 2);
            @(posedge clk);
            #1;
            cyc++;
        end
        data_out_ready = 1'b0;
        check("consume_count", hs_count - start, n);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        rst = 1'b1; reload = 1'b0; data_in_valid = 1'b0; data_in[0] = '0; data_out_ready = 1'b0;

        // Reset
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", data_in_ready, 0);
            check("rst_load_done", load_done, 0);
            check("rst_out_valid", data_out_valid, 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Continuous load 0x1000+i, then replay timing and 80-beat wrap
        load_beats(16'h1000, 1'b0, 32);
        data_out_ready = 1'b1;
        push_expected(80);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("first_valid_latency", data_out_valid, (k == 3));
            if (k == 0) begin
                check("load_done_rise", load_done, 1);
                check("serve_in_ready", data_in_ready, 0);
            end
        end
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            check("no_bubble", data_out_valid, 1);
            check("load_done_hold", load_done, 1);
        end
        @(posedge clk); #1 data_out_ready = 1'b0;
        check("replay_count", hs_count, 80);
        check("replay_queue_empty", exp_q.size(), 0);

        // Random backpressure with long stalls
        push_expected(64);
        consume(64, 1'b1);

        // Reload mid-SERVE after 5 beats
        push_expected(5);
        n = 0; g = 0;
        data_out_ready = 1'b1;
        while (n < 5 && g < 100) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) n++;
            g++;
        end
        @(posedge clk); #1;
        data_out_ready = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        check("reload_serve_in_ready", data_in_ready, 0);
        @(posedge clk); #1 reload = 1'b0;
        @(negedge clk);
        check("reload_out_valid", data_out_valid, 0);
        check("reload_load_done", load_done, 0);
        check("reload_in_ready", data_in_ready, 1);
        check("reload_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;

        // Gappy load of 0x2000+i, replay must start at 0x2000
        load_beats(16'h2000, 1'b1, 32);
        rep_idx = 0;
        push_expected(40);
        consume(40, 1'b0);

        // Reload mid-LOAD at wr_ptr=7 with valid high
        reload = 1'b1;
        @(posedge clk); #1 reload = 1'b0;
        load_beats(16'h4000, 1'b0, 7);
        data_in_valid = 1'b1;
        data_in[0]    = 16'h4007;
        reload        = 1'b1;
        @(negedge clk);
        check("reload_load_in_ready", data_in_ready, 0);
        @(posedge clk); #1;
        reload        = 1'b0;
        data_in_valid = 1'b0;
        load_beats(16'h3000, 1'b0, 32);
        rep_idx = 0;
        push_expected(40);
        consume(40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
